// File: rtl/multiword_add_seq_pkg.sv
// Shared types and sizing for the sequential 64-bit word-serial adder.
// Holds the FSM state enum, word geometry and the packed result-flag bundle.
package multiword_add_seq_pkg;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 4;
    localparam int TOTAL_W   = 64;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    typedef struct packed {
        logic carry;
        logic sign;
        logic zero;
        logic parity;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle of multiword_add_seq.
// master: start, input1, input2, cin out; busy, done, sum and flags in.
// slave : the mirror image, used by the adder itself.
interface multiword_add_seq_if;
    import multiword_add_seq_pkg::*;

    logic               start;
    logic [TOTAL_W-1:0] input1;
    logic [TOTAL_W-1:0] input2;
    logic               cin;
    logic               busy;
    logic               done;
    logic [TOTAL_W-1:0] sum;
    logic               carry;
    logic               sign;
    logic               zero;
    logic               parity;
    logic               overflow;

    modport master (
        output start, input1, input2, cin,
        input  busy, done, sum,
        input  carry, sign, zero, parity, overflow
    );

    modport slave (
        input  start, input1, input2, cin,
        output busy, done, sum,
        output carry, sign, zero, parity, overflow
    );

endinterface

// File: rtl/multiword_add_seq_add16_slice.sv
// Combinational one-word adder reused every ADD cycle.
// Ports: a, b (word operands), ci (carry in) -> s (word sum), co (carry out).
module add16_slice
    import multiword_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              ci,
    output logic [WORD_W-1:0] s,
    output logic              co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_seq.sv
// 64-bit adder computed one 16-bit word per cycle through a single slice.
// Ports: clk, rst (sync, active high), bus (slave: start/operands in, status/sum/flags out).
module multiword_add_seq
    import multiword_add_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TOTAL_W-1:0] a_q, a_d;
    logic [TOTAL_W-1:0] b_q, b_d;
    logic               c_q, c_d;
    logic [TOTAL_W-1:0] acc_q, acc_d;
    logic [TOTAL_W-1:0] sum_q, sum_d;
    flags_t             flags_q, flags_d;

    logic [WORD_W-1:0]  slice_s;
    logic               slice_co;

    add16_slice u_slice (
        .a  (a_q[idx_q*WORD_W +: WORD_W]),
        .b  (b_q[idx_q*WORD_W +: WORD_W]),
        .ci (c_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.input1;
                    b_d     = bus.input2;
                    c_d     = bus.cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[idx_q*WORD_W +: WORD_W] = slice_s;
                c_d   = slice_co;
                idx_d = idx_q + 1'b1;
                // Result and flags are published only once the top word lands,
                // so sum never shows a partially accumulated value.
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    state_d          = DONE;
                    sum_d            = acc_d;
                    flags_d.carry    = slice_co;
                    flags_d.sign     = acc_d[TOTAL_W-1];
                    flags_d.zero     = ~|acc_d;
                    flags_d.parity   = ~^acc_d;
                    flags_d.overflow = (a_q[TOTAL_W-1] == b_q[TOTAL_W-1]) &&
                                       (acc_d[TOTAL_W-1] != a_q[TOTAL_W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    assign bus.busy     = (state_q == ADD);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = flags_q.carry;
    assign bus.sign     = flags_q.sign;
    assign bus.zero     = flags_q.zero;
    assign bus.parity   = flags_q.parity;
    assign bus.overflow = flags_q.overflow;

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to begin a 64-bit add; sampled only when busy=0.
- input1  in  64  operand A; latched on an accepted start.
- input2  in  64  operand B; latched on an accepted start.
- cin  in  1  carry into word 0; latched on an accepted start.
- busy  out  1  high while word additions are in progress.
- done  out  1  one-cycle pulse when sum and flags are updated.
- sum  out  64  registered 64-bit result.
- carry  out  1  carry out of bit 63.
- sign  out  1  sum[63].
- zero  out  1  1 when all 64 sum bits are 0.
- parity  out  1  even-parity flag: 1 when the count of ones in sum is even.
- overflow  out  1  two's-complement signed overflow.

Function
REQ-002 The block SHALL have three states: IDLE, ADD and DONE.
REQ-003 In IDLE or DONE, start=1 SHALL latch input1, input2 and cin, clear the word index to 0, and enter ADD.
REQ-004 In ADD, each cycle SHALL add one 16-bit word k (bits 16k+15:16k), starting with k=0:
- A[k] + B[k] + carry register → 17-bit result.
- The low 16 bits go to the result register word k.
- Bit 16 becomes the new carry register value.
- cin seeds the carry register for k=0.
REQ-005 After word k=3 the block SHALL enter DONE; ADD therefore lasts exactly 4 cycles.
REQ-006 DONE SHALL last exactly one cycle, with done=1.
- With no start, DONE SHALL return to IDLE.
- With start=1, DONE SHALL re-enter ADD (back-to-back operation).
REQ-007 Latency: when start is accepted at edge T, done SHALL be high in the cycle following edge T+4.
- busy SHALL be high in the four cycles following edges T through T+3.
REQ-008 busy SHALL be 1 only in ADD; start while busy=1 SHALL be ignored, with no effect on latched operands.
REQ-009 sum and all flags SHALL update together on the edge entering DONE, and SHALL hold until the next DONE or reset.
REQ-010 During ADD, sum and flags SHALL hold the previous operation's values; partial results SHALL NOT appear on sum.
REQ-011 Flag definitions:
- carry = carry out of word 3.
- sign = sum[63].
- zero = NOR-reduction of sum.
- parity = XNOR-reduction of sum.
- overflow = (A[63]==B[63]) AND (sum[63]!=A[63]).
REQ-012 Arithmetic SHALL be modulo 2^64 with no saturation; a cin carry SHALL propagate through all four words.
REQ-013 Input operand changes after an accepted start SHALL NOT affect the operation in progress.

Reset
REQ-014 rst=1 at a clock edge SHALL force:
- state=IDLE and word index=0.
- busy=0, done=0.
- sum=0.
- carry=sign=zero=parity=overflow=0.
REQ-015 Reset SHALL take priority over start and over any ADD step.
REQ-016 Reset asserted mid-ADD SHALL abandon the operation with no done pulse.
REQ-017 After reset, the first start SHALL be accepted on the first edge at which rst=0.

Structure
REQ-018 A shared package SHALL hold the following:
- the state enum (IDLE, ADD, DONE);
- WORD_W=16;
- NUM_WORDS=4;
- TOTAL_W=64.
REQ-019 The per-word adder SHALL be a combinational sub-module add16_slice with ports (a[15:0], b[15:0], ci → s[15:0], co).
- The block SHALL instantiate add16_slice exactly once and reuse it each ADD cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Cross-word carry: input1=0x0000_0000_0000_FFFF, input2=0x1, cin=0.
  - Required: sum=0x0000_0000_0001_0000, carry=0, zero=0, parity=0, overflow=0.
  - Required: done exactly 5 cycles after start.
- Full wrap: input1=0xFFFF_FFFF_FFFF_FFFF, input2=0x1, cin=0.
  - Required: sum=0, carry=1, zero=1, parity=1, sign=0, overflow=0.
- Positive overflow: input1=0x7FFF_FFFF_FFFF_FFFF, input2=0x0, cin=1.
  - Required: sum=0x8000_0000_0000_0000, sign=1, overflow=1, carry=0, parity=0.
- Negative overflow: input1=input2=0x8000_0000_0000_0000.
  - Required: sum=0, carry=1, overflow=1, zero=1.
- Busy and reset:
  - Pulse start during the 2nd ADD cycle with different operands; required: ignored, original result delivered.
  - Separately, assert rst during the 3rd ADD cycle; required: all outputs 0 the next cycle and no done pulse.
- Back-to-back: start held high through DONE.
  - Required: the second operation begins from DONE; done pulses 5 cycles apart; busy is low only in the DONE cycle.
